// File: rtl/sc_tei0026_pio_input_edge.sv
// sc_tei0026_pio_input_edge
// Avalon-MM slave parallel input port. Brings an asynchronous WIDTH-bit bus
// into the clk domain through a SYNC_STAGES flop synchronizer, detects per-bit
// edges (rising, falling or any) into a sticky write-1-to-clear capture
// register, and raises a level interrupt for captured edges that are unmasked.
//
// Register window (word address):
//   0  data          RO  synchronized input, zero-extended
//   1  reserved      RO  reads 0
//   2  irq_mask      RW  bits [WIDTH-1:0]
//   3  edge_capture  RO / W1C
module sc_tei0026_pio_input_edge #(
  parameter int WIDTH       = 21,  // 1..32
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int EDGE_TYPE   = 0    // 0 rising, 1 falling, 2 any
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Synchronizer chain; element SYNC_STAGES-1 is the synchronized data_in.
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_data_in;
  logic [WIDTH-1:0] w_edge;
  logic             w_write;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clear;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_data_in = r_sync[SYNC_STAGES-1];

  // Bus decode: bits of writedata at or above WIDTH have no destination.
  assign w_write        = chipselect && !write_n;
  assign w_wr_mask      = w_write && (address == ADDR_MASK);
  assign w_wr_edge      = w_write && (address == ADDR_EDGE);
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_clear        = w_wr_edge ? w_wdata : '0;
  assign w_unused_wdata = ^{1'b0, writedata};

  // Edge detector selected at elaboration; compares data_in with its
  // one-cycle-delayed copy.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge = w_data_in & ~r_d1;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge = ~w_data_in & r_d1;
    end else begin : g_any
      assign w_edge = w_data_in ^ r_d1;
    end
  endgenerate

  // Input synchronizer and edge history register.
  // NOTE: the sync chain is a handful of flops, not a memory, so it is reset
  // like any other register; a reset-to-0 chain is what makes an input held
  // high through reset release show up as one rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_d1 <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, forming a true shift chain.
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_d1 <= w_data_in;
    end
  end

  // Interrupt mask register, written through address 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr_mask) begin
      r_irq_mask <= w_wdata;
    end
  end

  // Sticky edge capture: a detected edge sets, a written 1 clears, and set
  // wins over a simultaneous clear so no edge is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= w_edge | (r_edge_capture & ~w_clear);
    end
  end

  // Read mux over pre-update register values, zero-extended to 32 bits.
  always_comb begin
    // NOTE: default first so every path assigns w_rd_mux and no latch forms.
    w_rd_mux = '0;
    unique case (address)
      ADDR_DATA: w_rd_mux = 32'(w_data_in);
      ADDR_RSVD: w_rd_mux = '0;
      ADDR_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge_capture);
      default:   w_rd_mux = '0;
    endcase
  end

  // Registered read data: one-clock latency, updated regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

  // Level interrupt from registers only, so it cannot glitch; it drops
  // immediately on asynchronous reset because both sources clear.
  assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_sc_tei0026_pio_input_edge.sv
// tb_sc_tei0026_pio_input_edge
// Three instances (rising / falling / any edge) share one bus and one input
// bus. A reference model tracks the input history and register contents and
// every clock all readdata and irq outputs are compared against it, with
// directed steps for the documented scenarios followed by random traffic.
module tb_sc_tei0026_pio_input_edge;

  localparam int W = 21;
  localparam int S = 2;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  rd_r, rd_f, rd_a;
  logic         irq_r, irq_f, irq_a;

  always #5 clk = ~clk;

  sc_tei0026_pio_input_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd_r), .irq(irq_r));

  sc_tei0026_pio_input_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd_f), .irq(irq_f));

  sc_tei0026_pio_input_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd_a), .irq(irq_a));

  // Reference model: history of sampled inputs plus the visible registers.
  logic [W-1:0] m_hist [S];   // m_hist[S-1] is the synchronized value
  logic [W-1:0] m_prev;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [3];    // index = edge type
  logic [31:0]  m_rd  [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = '0;
    m_prev = '0;
    m_mask = '0;
    for (int k = 0; k < 3; k++) begin
      m_cap[k] = '0;
      m_rd[k]  = '0;
    end
  endtask

  // One clock of model behaviour, using the inputs present at the edge.
  task automatic model_clock();
    logic [W-1:0] cur;
    logic [W-1:0] det [3];
    logic [W-1:0] clr;
    logic         wr;
    cur    = m_hist[S-1];
    wr     = chipselect && !write_n;
    clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    det[0] = cur & ~m_prev;
    det[1] = ~cur & m_prev;
    det[2] = cur ^ m_prev;
    for (int k = 0; k < 3; k++) begin
      case (address)
        2'd0:    m_rd[k] = 32'(cur);
        2'd2:    m_rd[k] = 32'(m_mask);
        2'd3:    m_rd[k] = 32'(m_cap[k]);
        default: m_rd[k] = 32'h0;
      endcase
      m_cap[k] = det[k] | (m_cap[k] & ~clr);
    end
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev = cur;
    for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = in_port;
  endtask

  task automatic compare_all();
    check("rd_rise",  rd_r, m_rd[0]);
    check("rd_fall",  rd_f, m_rd[1]);
    check("rd_any",   rd_a, m_rd[2]);
    check("irq_rise", 32'(irq_r), 32'(|(m_cap[0] & m_mask)));
    check("irq_fall", 32'(irq_f), 32'(|(m_cap[1] & m_mask)));
    check("irq_any",  32'(irq_a), 32'(|(m_cap[2] & m_mask)));
  endtask

  // Inputs change only at negedge; outputs are compared at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic do_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = '0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset state: every address reads 0, no interrupt.
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      check("reset_read", rd_r, 32'h0);
    end
    check("reset_irq", 32'(irq_r), 32'h0);

    // Rising edges on bits 0 and 2, captured three clocks later.
    in_port = 21'h000005;
    address = 2'd3;
    ticks(3);
    check("latency_before", rd_r, 32'h0);
    tick();
    check("latency_capture", rd_r, 32'h5);
    do_read(2'd0);
    check("data_read", rd_r, 32'h5);
    do_read(2'd3);
    check("edge_rise", rd_r, 32'h5);
    check("edge_fall_none", rd_f, 32'h0);
    check("irq_unmasked", 32'(irq_r), 32'h0);

    // Mask, clear one bit, then the other.
    do_write(2'd2, 32'h4);
    check("irq_mask_on", 32'(irq_r), 32'h1);
    do_write(2'd3, 32'h4);
    check("irq_cleared", 32'(irq_r), 32'h0);
    do_read(2'd3);
    check("edge_after_clr", rd_r, 32'h1);
    do_write(2'd3, 32'h1);
    do_read(2'd3);
    check("edge_all_clr", rd_r, 32'h0);

    // Edge on bit 0 arriving in the same clock as its clear: set wins.
    do_write(2'd2, 32'h1);
    in_port = 21'h000004;
    ticks(4);
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 21'h000005;
    ticks(2);
    do_write(2'd3, 32'h1);
    check("set_wins_irq", 32'(irq_r), 32'h1);
    do_read(2'd3);
    check("set_wins_edge", rd_r, 32'h1);

    // Pulse bit 20: falling mode only on 1->0, any mode on both.
    ticks(4);
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 21'h100005;
    ticks(4);
    do_read(2'd3);
    check("pulse_up_rise", rd_r, 32'h0010_0000);
    check("pulse_up_fall", rd_f, 32'h0);
    check("pulse_up_any",  rd_a, 32'h0010_0000);
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 21'h000005;
    ticks(4);
    do_read(2'd3);
    check("pulse_dn_rise", rd_r, 32'h0);
    check("pulse_dn_fall", rd_f, 32'h0010_0000);
    check("pulse_dn_any",  rd_a, 32'h0010_0000);

    // Upper writedata bits are dropped.
    do_write(2'd2, 32'hFFFF_FFFF);
    do_read(2'd2);
    check("mask_width", rd_r, 32'h001F_FFFF);

    // Writes to data and reserved addresses have no effect.
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1);
    check("reserved_read", rd_r, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(3));
      chipselect = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Fill every capture bit with the mask fully on, then reset mid-operation.
    do_write(2'd2, 32'hFFFF_FFFF);
    in_port = '0;
    ticks(4);
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = ALL1;
    ticks(4);
    do_read(2'd3);
    check("full_capture", rd_r, 32'h001F_FFFF);
    check("full_irq", 32'(irq_r), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq_r), 32'h0);
    check("async_rd",  rd_r, 32'h0);
    check("async_irq_any", 32'(irq_a), 32'h0);
    model_reset();
    @(negedge clk);
    in_port = 21'h000001;
    address = 2'd3;
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    check("rel_before", rd_r, 32'h0);
    tick();
    check("rel_capture", rd_r, 32'h1);
    check("rel_fall", rd_f, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
